// File: rtl/wb_mem_responder_pkg.sv
// Shared Wishbone lane masks, the latched request record and small bus helpers.
package wb_mem_responder_pkg;

    // Byte-lane strobe masks, shared with the load/store units.
    localparam logic [3:0] WB_LANE_0    = 4'b0001;
    localparam logic [3:0] WB_LANE_1    = 4'b0010;
    localparam logic [3:0] WB_LANE_2    = 4'b0100;
    localparam logic [3:0] WB_LANE_3    = 4'b1000;
    localparam logic [3:0] WB_LANE_LO   = 4'b0011;
    localparam logic [3:0] WB_LANE_HI   = 4'b1100;
    localparam logic [3:0] WB_LANE_WORD = 4'b1111;

    // Request fields captured on acceptance and held for the whole transfer.
    typedef struct packed {
        logic        we;
        logic [3:0]  stb;
        logic [31:0] dat;
        logic        in_win;
    } wb_req_t;

    // A bus request needs an open cycle and at least one strobed lane.
    function automatic logic wb_is_req(input logic cyc, input logic [3:0] stb);
        return cyc && (|stb);
    endfunction

endpackage

// File: rtl/wb_mem_responder_if.sv
// Wishbone bus between the CPU master and the memory responder.
interface wb_mem_responder_if;
    logic [31:0] addr;
    logic        cyc;
    logic [3:0]  stb;
    logic        we;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;
    logic        err;

    modport master (
        output addr, cyc, stb, we, wdat,
        input  rdat, ack, err
    );

    modport slave (
        input  addr, cyc, stb, we, wdat,
        output rdat, ack, err
    );
endinterface

// File: rtl/wb_mem_responder_mem_be32.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read port.
module mem_be32 #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  i_clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdat,
    output logic [31:0]           rdat
);
    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    // Byte-lane write and read-before-write registered output, block-RAM style.
    always_ff @(posedge i_clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we && be[i]) begin
                    mem[addr][8*i +: 8] <= wdat[8*i +: 8];
                end
            end
            rdat <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone word-memory responder with programmable wait states and
// out-of-window error response.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for cyc && |stb; captures the request on acceptance
// S_WAIT | counting wait states down; cyc dropping aborts with no response
// S_RESP | single ack or err cycle; always returns to S_IDLE next
module wb_mem_responder
    import wb_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input logic               i_clk,
    input logic               i_reset,
    wb_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam bit         NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t                state;
    logic [3:0]            cnt;
    wb_req_t               req_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  ack_q;
    logic                  err_q;
    logic                  rd_q;

    logic [29:0]           word_off;
    logic                  in_win;
    logic                  req;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [1:0]            unused_addr_lsb;

    logic                  ram_en;
    logic                  ram_we;
    logic [3:0]            ram_be;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [31:0]           ram_wdat;
    logic [31:0]           ram_rdat;

    // BASE_ADDR is window-aligned, so the word offset can be taken on bits [31:2].
    assign word_off        = bus.addr[31:2] - BASE_ADDR[31:2];
    assign in_win          = (word_off >> ADDR_WIDTH) == 30'd0;
    assign cur_idx         = word_off[ADDR_WIDTH-1:0];
    assign req             = wb_is_req(bus.cyc, bus.stb);
    assign unused_addr_lsb = bus.addr[1:0];

    // RAM port: live bus fields on a zero-wait acceptance, otherwise the
    // captured request on the last wait cycle so the read lands in S_RESP.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_be   = req_q.stb;
        ram_idx  = idx_q;
        ram_wdat = req_q.dat;
        if (!i_reset) begin
            if (NO_WAIT && state == S_IDLE && req) begin
                ram_en   = in_win;
                ram_we   = in_win && bus.we;
                ram_be   = bus.stb;
                ram_idx  = cur_idx;
                ram_wdat = bus.wdat;
            end else if (state == S_WAIT && bus.cyc && cnt == 4'd1) begin
                ram_en = req_q.in_win;
                ram_we = req_q.in_win && req_q.we;
            end
        end
    end

    mem_be32 #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_mem (
        .i_clk (i_clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_idx),
        .wdat  (ram_wdat),
        .rdat  (ram_rdat)
    );

    // Transfer sequencing with ack/err/read-valid registered on S_RESP entry.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rd_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        req_q <= '{we: bus.we, stb: bus.stb, dat: bus.wdat, in_win: in_win};
                        idx_q <= cur_idx;
                        if (NO_WAIT) begin
                            state <= S_RESP;
                            ack_q <= in_win;
                            err_q <= !in_win;
                            rd_q  <= in_win && !bus.we;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.cyc) begin
                        state <= S_IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd1) begin
                        state <= S_RESP;
                        cnt   <= 4'd0;
                        ack_q <= req_q.in_win;
                        err_q <= !req_q.in_win;
                        rd_q  <= req_q.in_win && !req_q.we;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.ack  = ack_q;
    assign bus.err  = err_q;
    assign bus.rdat = rd_q ? ram_rdat : 32'h0;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench: three responders with 0, 3 and 4 wait states on one clock.
module tb_wb_mem_responder;
    import wb_mem_responder_pkg::*;

    localparam int ND = 3;
    localparam int WS [ND] = '{0, 3, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [ND];
    logic [31:0] m_addr [ND];
    logic        m_cyc  [ND];
    logic [3:0]  m_stb  [ND];
    logic        m_we   [ND];
    logic [31:0] m_wdat [ND];
    logic [31:0] s_dat  [ND];
    logic        s_ack  [ND];
    logic        s_err  [ND];

    int n_chk  = 0;
    int n_fail = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        wb_mem_responder_if bus ();
        assign bus.addr  = m_addr[g];
        assign bus.cyc   = m_cyc[g];
        assign bus.stb   = m_stb[g];
        assign bus.we    = m_we[g];
        assign bus.wdat  = m_wdat[g];
        assign s_dat[g]  = bus.rdat;
        assign s_ack[g]  = bus.ack;
        assign s_err[g]  = bus.err;

        wb_mem_responder #(
            .ADDR_WIDTH  (10),
            .BASE_ADDR   (32'h0000_0000),
            .WAIT_STATES (WS[g]),
            .INIT_FILE   ("")
        ) u_dut (
            .i_clk   (clk),
            .i_reset (rst[g]),
            .bus     (bus)
        );
    end

    // One transfer on responder d; inputs are scrambled right after acceptance.
    task automatic xfer(input int d, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s,
                        output logic [31:0] rd, output logic ak, output logic er,
                        output int lat, output int pulses, output int stray);
        @(negedge clk);
        m_addr[d] = a; m_we[d] = we; m_wdat[d] = wd; m_stb[d] = s; m_cyc[d] = 1'b1;
        @(posedge clk);
        #1;
        m_addr[d] = a ^ 32'h8; m_we[d] = ~we; m_wdat[d] = ~wd;
        rd = 32'h0; ak = 1'b0; er = 1'b0; lat = 0; pulses = 0; stray = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (s_ack[d] === 1'b1 || s_err[d] === 1'b1) begin
                pulses++;
                if (lat == 0) begin
                    lat = i; ak = s_ack[d]; er = s_err[d]; rd = s_dat[d];
                end
                m_cyc[d] = 1'b0; m_stb[d] = 1'b0;
            end
            if (s_dat[d] !== 32'h0 && !(s_ack[d] === 1'b1 && !we)) stray++;
        end
        m_cyc[d] = 1'b0; m_stb[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1; m_cyc[d] = 1'b0; m_stb[d] = 4'h0; m_we[d] = 1'b0;
            m_addr[d] = 32'h0; m_wdat[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            n_chk++; if (s_ack[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ack[%0d]: got %b expected 0", d, s_ack[d]); end
            n_chk++; if (s_err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b expected 0", d, s_err[d]); end
            n_chk++; if (s_dat[d] !== 32'h0) begin n_fail++; $display("FAIL reset_dat[%0d]: got %h expected 0", d, s_dat[d]); end
            rst[d] = 1'b0;
        end
        // cyc high with no strobes, then strobes with cyc low: neither is a request
        m_cyc[0] = 1'b1; m_stb[0] = 4'h0;
        @(negedge clk);
        m_cyc[0] = 1'b0; m_stb[0] = WB_LANE_WORD;
        repeat (3) @(negedge clk);
        n_chk++; if (s_ack[0] !== 1'b0 || s_err[0] !== 1'b0) begin n_fail++; $display("FAIL non_request: got ack %b err %b expected 0 0", s_ack[0], s_err[0]); end
        m_stb[0] = 4'h0;
    endtask

    task automatic test_word_rw();
        logic [31:0] rd; logic ak, er; int lat, pulses, stray;
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        n_chk++; if (ak !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL w0_ack: got ack %b err %b expected 1 0", ak, er); end
        n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL w0_latency: got %0d expected 1", lat); end
        n_chk++; if (pulses !== 1 || stray !== 0) begin n_fail++; $display("FAIL w0_pulses: got %0d/%0d expected 1/0", pulses, stray); end
        xfer(0, 1'b0, 32'h10, 32'h0, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL r0_data: got %h expected deadbeef", rd); end
        n_chk++; if (lat !== 1 || ak !== 1'b1) begin n_fail++; $display("FAIL r0_latency: got %0d ack %b expected 1 1", lat, ak); end
        n_chk++; if (pulses !== 1 || stray !== 0) begin n_fail++; $display("FAIL r0_pulses: got %0d/%0d expected 1/0", pulses, stray); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic ak, er; int lat, pulses, stray;
        xfer(0, 1'b1, 32'h10, 32'h000000AA, WB_LANE_0, rd, ak, er, lat, pulses, stray);
        xfer(0, 1'b1, 32'h10, 32'h55000000, WB_LANE_3, rd, ak, er, lat, pulses, stray);
        n_chk++; if (ak !== 1'b1) begin n_fail++; $display("FAIL lane3_ack: got %b expected 1", ak); end
        xfer(0, 1'b0, 32'h10, 32'h0, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        n_chk++; if (rd !== 32'h55ADBEAA) begin n_fail++; $display("FAIL lane_merge: got %h expected 55adbeaa", rd); end
        xfer(0, 1'b1, 32'h10, 32'h12340000, WB_LANE_HI, rd, ak, er, lat, pulses, stray);
        xfer(0, 1'b0, 32'h10, 32'h0, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        n_chk++; if (rd !== 32'h1234BEAA) begin n_fail++; $display("FAIL half_merge: got %h expected 1234beaa", rd); end
        xfer(0, 1'b0, 32'h10, 32'h0, WB_LANE_0, rd, ak, er, lat, pulses, stray);
        n_chk++; if (rd !== 32'h1234BEAA) begin n_fail++; $display("FAIL read_unmasked: got %h expected 1234beaa", rd); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic ak, er; int lat, pulses, stray;
        xfer(1, 1'b1, 32'h40, 32'hA5A55A5A, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        n_chk++; if (lat !== 4 || ak !== 1'b1) begin n_fail++; $display("FAIL ws3_write_lat: got %0d ack %b expected 4 1", lat, ak); end
        n_chk++; if (pulses !== 1) begin n_fail++; $display("FAIL ws3_write_pulses: got %0d expected 1", pulses); end
        xfer(1, 1'b0, 32'h40, 32'h0, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        n_chk++; if (lat !== 4 || ak !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL ws3_read_lat: got %0d ack %b err %b expected 4 1 0", lat, ak, er); end
        n_chk++; if (rd !== 32'hA5A55A5A) begin n_fail++; $display("FAIL ws3_read_data: got %h expected a5a55a5a", rd); end
        n_chk++; if (pulses !== 1 || stray !== 0) begin n_fail++; $display("FAIL ws3_read_pulses: got %0d/%0d expected 1/0", pulses, stray); end
    endtask

    task automatic test_out_of_window();
        logic [31:0] rd; logic ak, er; int lat, pulses, stray;
        xfer(0, 1'b1, 32'h0, 32'h0BADF00D, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        xfer(0, 1'b0, 32'h1000, 32'h0, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        n_chk++; if (er !== 1'b1 || ak !== 1'b0) begin n_fail++; $display("FAIL oow_read_resp: got ack %b err %b expected 0 1", ak, er); end
        n_chk++; if (lat !== 1 || pulses !== 1) begin n_fail++; $display("FAIL oow_read_pulse: got lat %0d pulses %0d expected 1 1", lat, pulses); end
        n_chk++; if (rd !== 32'h0 || stray !== 0) begin n_fail++; $display("FAIL oow_read_dat: got %h stray %0d expected 0 0", rd, stray); end
        xfer(0, 1'b1, 32'h1000, 32'hFFFFFFFF, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        n_chk++; if (er !== 1'b1 || ak !== 1'b0) begin n_fail++; $display("FAIL oow_write_resp: got ack %b err %b expected 0 1", ak, er); end
        xfer(0, 1'b0, 32'h0, 32'h0, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        n_chk++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL oow_word0: got %h expected 0badf00d", rd); end
        xfer(0, 1'b1, 32'hFFC, 32'h600DCAFE, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        n_chk++; if (ak !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL top_word_write: got ack %b err %b expected 1 0", ak, er); end
        xfer(0, 1'b0, 32'hFFC, 32'h0, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        n_chk++; if (rd !== 32'h600DCAFE) begin n_fail++; $display("FAIL top_word_read: got %h expected 600dcafe", rd); end
        xfer(0, 1'b0, 32'hFFFFFFFC, 32'h0, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        n_chk++; if (er !== 1'b1 || ak !== 1'b0) begin n_fail++; $display("FAIL oow_high: got ack %b err %b expected 0 1", ak, er); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic ak, er; int lat, pulses, stray, seen;
        xfer(2, 1'b1, 32'h20, 32'hCAFEF00D, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        n_chk++; if (lat !== 5 || ak !== 1'b1) begin n_fail++; $display("FAIL ws4_write_lat: got %0d ack %b expected 5 1", lat, ak); end
        @(negedge clk);
        m_addr[2] = 32'h20; m_we[2] = 1'b1; m_wdat[2] = 32'h12345678; m_stb[2] = WB_LANE_WORD; m_cyc[2] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        m_cyc[2] = 1'b0; m_stb[2] = 4'h0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (s_ack[2] !== 1'b0 || s_err[2] !== 1'b0) seen++;
        end
        n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL abort_resp: got %0d response cycles expected 0", seen); end
        xfer(2, 1'b0, 32'h20, 32'h0, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        n_chk++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL abort_nowrite: got %h expected cafef00d", rd); end
        n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL ws4_read_lat: got %0d expected 5", lat); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic ak, er; int lat, pulses, stray, seen;
        xfer(1, 1'b1, 32'h30, 32'h11112222, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        @(negedge clk);
        m_addr[1] = 32'h30; m_we[1] = 1'b1; m_wdat[1] = 32'h99999999; m_stb[1] = WB_LANE_WORD; m_cyc[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        n_chk++; if (s_ack[1] !== 1'b0 || s_err[1] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_resp: got ack %b err %b expected 0 0", s_ack[1], s_err[1]); end
        n_chk++; if (s_dat[1] !== 32'h0) begin n_fail++; $display("FAIL rst_mid_dat: got %h expected 0", s_dat[1]); end
        rst[1] = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 4'h0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (s_ack[1] !== 1'b0 || s_err[1] !== 1'b0) seen++;
        end
        n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d response cycles expected 0", seen); end
        xfer(1, 1'b0, 32'h30, 32'h0, WB_LANE_WORD, rd, ak, er, lat, pulses, stray);
        n_chk++; if (rd !== 32'h11112222) begin n_fail++; $display("FAIL rst_mid_nowrite: got %h expected 11112222", rd); end
        n_chk++; if (lat !== 4 || pulses !== 1) begin n_fail++; $display("FAIL rst_mid_relat: got lat %0d pulses %0d expected 4 1", lat, pulses); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat0; logic [9:0] pat1; int good;
        @(negedge clk);
        m_addr[0] = 32'h10; m_we[0] = 1'b0; m_stb[0] = WB_LANE_WORD; m_cyc[0] = 1'b1;
        pat0 = '0; good = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (s_ack[0] === 1'b1) begin pat0[i] = 1'b1; if (s_dat[0] === 32'h1234BEAA) good++; end
        end
        m_cyc[0] = 1'b0; m_stb[0] = 4'h0;
        n_chk++; if (pat0 !== 6'b010101) begin n_fail++; $display("FAIL b2b_ws0_pattern: got %b expected 010101", pat0); end
        n_chk++; if (good !== 3) begin n_fail++; $display("FAIL b2b_ws0_data: got %0d good reads expected 3", good); end
        @(negedge clk);
        m_addr[1] = 32'h40; m_we[1] = 1'b0; m_stb[1] = WB_LANE_WORD; m_cyc[1] = 1'b1;
        pat1 = '0; good = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (s_ack[1] === 1'b1) begin pat1[i] = 1'b1; if (s_dat[1] === 32'hA5A55A5A) good++; end
        end
        m_cyc[1] = 1'b0; m_stb[1] = 4'h0;
        n_chk++; if (pat1 !== 10'b0100001000) begin n_fail++; $display("FAIL b2b_ws3_pattern: got %b expected 0100001000", pat1); end
        n_chk++; if (good !== 2) begin n_fail++; $display("FAIL b2b_ws3_data: got %0d good reads expected 2", good); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_wait_states();
        test_out_of_window();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
